// File: rtl/flush_ctrl_if.sv
// Event, instruction-bus and redirect signals of flush_ctrl; master drives events, slave is the sequencer.
interface flush_ctrl_if;
    logic        ws_ex_taken;
    logic        ws_tlb_flush;
    logic [31:0] ex_target;
    logic [31:0] refetch_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_req_hs;
    logic        inst_resp;
    logic        redirect_ready;
    logic        flush_out;
    logic        fe_cancel;
    logic        fetch_stall;
    logic        discard_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
`ifdef FLUSH_CTRL_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_drain_cyc;
`endif

    modport master (
        output ws_ex_taken, ws_tlb_flush, ex_target, refetch_pc,
        output br_taken, br_target, inst_req_hs, inst_resp, redirect_ready,
`ifdef FLUSH_CTRL_PERF_EN
        input  perf_flush_cnt, perf_drain_cyc,
`endif
        input  flush_out, fe_cancel, fetch_stall, discard_resp,
        input  redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  ws_ex_taken, ws_tlb_flush, ex_target, refetch_pc,
        input  br_taken, br_target, inst_req_hs, inst_resp, redirect_ready,
`ifdef FLUSH_CTRL_PERF_EN
        output perf_flush_cnt, perf_drain_cyc,
`endif
        output flush_out, fe_cancel, fetch_stall, discard_resp,
        output redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/flush_ctrl.sv
// Flush/redirect sequencer: drains stale inst responses, then presents one redirect PC (FLUSH_CTRL_PERF_EN adds perf counters).
// Latency: event to redirect_valid is 1 cycle, plus one cycle per outstanding response to discard.
// Backpressure: redirect held until redirect_ready; fetch_stall blocks requests while busy or at OUTSTANDING_MAX.
module flush_ctrl #(
    parameter int OUTSTANDING_MAX = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       resetn,
    flush_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] discard_cnt;
    logic [31:0]      target;
    logic [31:0]      event_target;
    logic             flush_q;
    logic             cancel_q;
    logic             resp_ok;
    logic             wb_event;
    logic             br_event;
    logic             any_event;

    // A response with nothing in flight is spurious and must not underflow the counter.
    assign resp_ok   = bus.inst_resp & (outstanding != '0);
    assign wb_event  = bus.ws_ex_taken | bus.ws_tlb_flush;
    assign br_event  = bus.br_taken & (state == IDLE);
    assign any_event = wb_event | br_event;

    always_comb begin
        outstanding_nxt = outstanding;
        if (bus.inst_req_hs && !resp_ok)
            outstanding_nxt = outstanding + CNT_W'(1);
        else if (!bus.inst_req_hs && resp_ok)
            outstanding_nxt = outstanding - CNT_W'(1);
    end

    always_comb begin
        event_target = bus.br_target;
        if (bus.ws_ex_taken)
            event_target = bus.ex_target;
        else if (bus.ws_tlb_flush)
            event_target = bus.refetch_pc;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            outstanding <= '0;
            discard_cnt <= '0;
            target      <= '0;
            flush_q     <= 1'b0;
            cancel_q    <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            flush_q     <= wb_event;
            cancel_q    <= any_event;
            // Everything still in flight after this edge belongs to the abandoned stream.
            if (any_event) begin
                target      <= event_target;
                discard_cnt <= outstanding_nxt;
                state       <= (outstanding_nxt != '0) ? DRAIN : REDIRECT;
            end else begin
                case (state)
                    DRAIN: begin
                        if (bus.inst_resp) begin
                            discard_cnt <= discard_cnt - CNT_W'(1);
                            if (discard_cnt == CNT_W'(1))
                                state <= REDIRECT;
                        end
                    end
                    REDIRECT: begin
                        if (bus.redirect_ready)
                            state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.flush_out      = flush_q;
    assign bus.fe_cancel      = cancel_q;
    assign bus.busy           = (state != IDLE);
    assign bus.fetch_stall    = (state != IDLE) | (outstanding == CNT_W'(OUTSTANDING_MAX));
    assign bus.discard_resp   = bus.inst_resp & (state == DRAIN);
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = target;

`ifdef FLUSH_CTRL_PERF_EN
    logic [31:0] perf_flush_cnt_q;
    logic [31:0] perf_drain_cyc_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_flush_cnt_q <= '0;
            perf_drain_cyc_q <= '0;
        end else begin
            if (wb_event)
                perf_flush_cnt_q <= perf_flush_cnt_q + 32'd1;
            if (state == DRAIN)
                perf_drain_cyc_q <= perf_drain_cyc_q + 32'd1;
        end
    end

    assign bus.perf_flush_cnt = perf_flush_cnt_q;
    assign bus.perf_drain_cyc = perf_drain_cyc_q;
`endif

endmodule

// File: tb/tb_flush_ctrl.sv
// Bench for flush_ctrl: directed scenarios then random traffic against an epoch-tagged in-flight request model.
module tb_flush_ctrl;
    localparam int OMAX = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    flush_ctrl_if bus ();

    flush_ctrl #(.OUTSTANDING_MAX(OMAX), .CNT_W(3)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Each in-flight request carries the stream epoch it was fetched in; older epochs are stale.
    int          q[$];
    int          epoch;
    bit          pend;
    logic [31:0] tgt;
    bit          e_flush;
    bit          e_cancel;
    logic [31:0] e_pflush;
    logic [31:0] e_pdrain;

    function automatic int stale_cnt();
        int n = 0;
        foreach (q[i]) if (q[i] != epoch) n++;
        return n;
    endfunction

    function automatic bit exp_stall();
        return pend || (q.size() >= OMAX);
    endfunction

    task automatic reset_model();
        q.delete();
        epoch    = 0;
        pend     = 1'b0;
        tgt      = '0;
        e_flush  = 1'b0;
        e_cancel = 1'b0;
        e_pflush = '0;
        e_pdrain = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        bit rv;
        bit disc;
        rv   = pend && (stale_cnt() == 0);
        disc = bus.inst_resp && (q.size() > 0) && (q[0] != epoch);
        chk("flush_out", bus.flush_out, e_flush);
        chk("fe_cancel", bus.fe_cancel, e_cancel);
        chk("busy", bus.busy, pend);
        chk("fetch_stall", bus.fetch_stall, exp_stall());
        chk("discard_resp", bus.discard_resp, disc);
        chk("redirect_valid", bus.redirect_valid, rv);
        if (rv) chk("redirect_pc", bus.redirect_pc, tgt);
`ifdef FLUSH_CTRL_PERF_EN
        chk("perf_flush_cnt", bus.perf_flush_cnt, e_pflush);
        chk("perf_drain_cyc", bus.perf_drain_cyc, e_pdrain);
`endif
    endtask

    task automatic model_edge();
        bit rv;
        bit wb;
        bit acc_br;
        int stl;
        stl    = stale_cnt();
        rv     = pend && (stl == 0);
        wb     = bus.ws_ex_taken || bus.ws_tlb_flush;
        acc_br = bus.br_taken && !pend;
        if (bus.inst_resp && q.size() > 0) void'(q.pop_front());
        if (bus.inst_req_hs) q.push_back(epoch);
        e_flush  = wb;
        e_cancel = wb || acc_br;
        if (wb) e_pflush = e_pflush + 32'd1;
        if (pend && stl > 0) e_pdrain = e_pdrain + 32'd1;
        if (wb || acc_br) begin
            epoch++;
            pend = 1'b1;
            tgt  = bus.ws_ex_taken ? bus.ex_target : (bus.ws_tlb_flush ? bus.refetch_pc : bus.br_target);
        end else if (rv && bus.redirect_ready) begin
            pend = 1'b0;
        end
    endtask

    task automatic idle();
        bus.ws_ex_taken    = 1'b0;
        bus.ws_tlb_flush   = 1'b0;
        bus.br_taken       = 1'b0;
        bus.inst_req_hs    = 1'b0;
        bus.inst_resp      = 1'b0;
        bus.redirect_ready = 1'b0;
    endtask

    // Inputs are applied at the falling edge; outputs are checked 1 time unit later.
    task automatic step();
        #1;
        check_all();
        model_edge();
        @(negedge clk);
        idle();
    endtask

    initial begin
        resetn         = 1'b1;
        bus.ex_target  = '0;
        bus.refetch_pc = '0;
        bus.br_target  = '0;
        idle();
        reset_model();
        #2 resetn = 1'b0;
        @(negedge clk);
        #1;
        check_all();
        chk("rst_pc", bus.redirect_pc, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Exception with nothing outstanding: redirect one cycle later.
        bus.ws_ex_taken = 1'b1;
        bus.ex_target   = 32'h1c008000;
        step();
        chk("p1_flush", bus.flush_out, 1);
        chk("p1_rv", bus.redirect_valid, 1);
        chk("p1_pc", bus.redirect_pc, 32'h1c008000);
        bus.redirect_ready = 1'b1;
        step();
        chk("p1_busy", bus.busy, 0);

        // Branch with three requests in flight.
        repeat (3) begin bus.inst_req_hs = 1'b1; step(); end
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c000100;
        step();
        chk("p2_flush", bus.flush_out, 0);
        chk("p2_cancel", bus.fe_cancel, 1);
        for (int i = 0; i < 3; i++) begin
            chk("p2_rv_low", bus.redirect_valid, 0);
            bus.inst_resp = 1'b1;
            #1 chk("p2_disc", bus.discard_resp, 1);
            step();
        end
        chk("p2_rv", bus.redirect_valid, 1);
        chk("p2_pc", bus.redirect_pc, 32'h1c000100);
        bus.redirect_ready = 1'b1;
        step();

        // All three event sources at once: the exception wins.
        bus.ws_ex_taken  = 1'b1;
        bus.ex_target    = 32'h1c008000;
        bus.ws_tlb_flush = 1'b1;
        bus.refetch_pc   = 32'h1c0000a4;
        bus.br_taken     = 1'b1;
        bus.br_target    = 32'h1c000200;
        step();
        chk("p3_pc", bus.redirect_pc, 32'h1c008000);
        bus.redirect_ready = 1'b1;
        step();

        // Refetch arriving mid-drain with a response in the same cycle.
        repeat (3) begin bus.inst_req_hs = 1'b1; step(); end
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h1c000300;
        step();
        bus.inst_resp = 1'b1;
        step();
        bus.ws_tlb_flush = 1'b1;
        bus.refetch_pc   = 32'h1c000044;
        bus.inst_resp    = 1'b1;
        step();
        chk("p4_flush", bus.flush_out, 1);
        chk("p4_rv_low", bus.redirect_valid, 0);
        bus.inst_resp = 1'b1;
        step();
        chk("p4_rv", bus.redirect_valid, 1);
        chk("p4_pc", bus.redirect_pc, 32'h1c000044);
        bus.redirect_ready = 1'b1;
        step();

        // Outstanding limit and simultaneous request/response.
        repeat (4) begin bus.inst_req_hs = 1'b1; step(); end
        chk("p5_stall_full", bus.fetch_stall, 1);
        bus.inst_resp = 1'b1;
        step();
        chk("p5_stall_free", bus.fetch_stall, 0);
        bus.inst_req_hs = 1'b1;
        bus.inst_resp   = 1'b1;
        step();
        chk("p5_stall_same", bus.fetch_stall, 0);
        bus.inst_req_hs = 1'b1;
        step();
        chk("p5_stall_again", bus.fetch_stall, 1);
        repeat (4) begin bus.inst_resp = 1'b1; step(); end

        // Asynchronous reset while draining two responses.
        repeat (2) begin bus.inst_req_hs = 1'b1; step(); end
        bus.br_taken = 1'b1;
        step();
        resetn = 1'b0;
        #1;
        chk("p6_busy", bus.busy, 0);
        chk("p6_cancel", bus.fe_cancel, 0);
        chk("p6_stall", bus.fetch_stall, 0);
        chk("p6_rv", bus.redirect_valid, 0);
        chk("p6_pc", bus.redirect_pc, 32'h0);
        reset_model();
        check_all();
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            bus.ws_ex_taken    = ($urandom_range(99) < 3);
            bus.ws_tlb_flush   = ($urandom_range(99) < 3);
            bus.br_taken       = ($urandom_range(99) < 8);
            bus.ex_target      = $urandom;
            bus.refetch_pc     = $urandom;
            bus.br_target      = $urandom;
            bus.inst_req_hs    = !exp_stall() && ($urandom_range(99) < 50);
            bus.inst_resp      = (q.size() > 0) ? ($urandom_range(99) < 40) : ($urandom_range(99) < 5);
            bus.redirect_ready = ($urandom_range(99) < 50);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
- Pipeline redirect/flush sequencer between the writeback stage and the fetch front end.
- Takes exception/ertn and TLB/CSR refetch events from WB and taken-branch redirects from EX.
- Tracks outstanding instruction-bus requests and discards stale responses before the new fetch stream starts.
- Presents a single redirect PC to pre-IF.

Parameters:
OUTSTANDING_MAX, 4, max in-flight instruction requests (must be 2..7)
CNT_W, 3, width of outstanding/discard counters; 2^CNT_W > OUTSTANDING_MAX

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ws_ex_taken  in  1  WB exception or ertn this cycle
ws_tlb_flush  in  1  WB TLB-op/CSR refetch this cycle
ex_target  in  32  exception entry / ERA target for ws_ex_taken
refetch_pc  in  32  WB pc+4 for ws_tlb_flush
br_taken  in  1  EX taken branch
br_target  in  32  branch target
inst_req_hs  in  1  instruction request handshake (req & addr_ok)
inst_resp  in  1  instruction data_ok
redirect_ready  in  1  pre-IF accepts redirect
flush_out  out  1  one-cycle pipeline flush to IF..MEM
fe_cancel  out  1  one-cycle front-end cancel (any event)
fetch_stall  out  1  block new instruction requests
discard_resp  out  1  current inst_resp is stale, drop it
redirect_valid  out  1  redirect PC valid
redirect_pc  out  32  redirect target
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, resetn=0): state IDLE, outstanding=0, discard_cnt=0, target=0, all outputs 0.
- Outstanding counter: outstanding_nxt = outstanding + inst_req_hs - inst_resp. Simultaneous hs and resp leave it unchanged. inst_resp with outstanding=0 is ignored; the counter does not go negative.
- fetch_stall = (state != IDLE) | (outstanding == OUTSTANDING_MAX).
- Event priority, same cycle: ws_ex_taken > ws_tlb_flush > br_taken.
- WB events are accepted in any state. br_taken is accepted only in IDLE; otherwise it is ignored as wrong-path.
- On an accepted event at cycle T:
  - target latched: ex_target, refetch_pc or br_target.
  - discard_cnt <= outstanding_nxt, minus 1 if inst_resp at T is itself being discarded (state DRAIN).
  - At T+1, registered: fe_cancel=1 for all events; flush_out=1 only for WB events.
- States:
  - IDLE: on event -> DRAIN if discard_cnt_nxt != 0, else REDIRECT.
  - DRAIN: discard_resp = inst_resp (combinational). Each inst_resp decrements discard_cnt. When discard_cnt is 1 and inst_resp=1 -> REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc=target. The pair is held stable until redirect_ready=1, then -> IDLE at the next edge.
  - A new WB event in DRAIN or REDIRECT re-latches target, reloads discard_cnt from outstanding_nxt, re-pulses flush_out/fe_cancel, and follows the IDLE transition rules.
- In IDLE, discard_resp=0 and inst_resp passes through normally.
- inst_req_hs while fetch_stall=1 is a protocol error. It is still counted in outstanding, so draining stays correct.
- Event to earliest redirect_valid latency: 1 cycle with nothing outstanding; 1 + N response cycles otherwise.

Optional Feature:
- Macro FLUSH_CTRL_PERF_EN.
- When defined, adds outputs perf_flush_cnt[31:0] and perf_drain_cyc[31:0]:
  - perf_flush_cnt counts accepted WB events.
  - perf_drain_cyc counts cycles spent in DRAIN.
  - Both wrap at 2^32 and reset to 0.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Idle, outstanding=0, ws_ex_taken=1, ex_target=0x1c008000 -> T+1 flush_out=1, fe_cancel=1; redirect_valid=1, redirect_pc=0x1c008000 at T+1; redirect_ready=1 -> IDLE, busy=0.
- 3 requests outstanding, br_taken, br_target=0x1c000100 -> flush_out=0, fe_cancel=1; next 3 inst_resp give discard_resp=1; redirect_valid rises the cycle after the 3rd resp.
- Same cycle ws_ex_taken=1 (target 0x1c008000), ws_tlb_flush=1 (0x1c0000a4), br_taken=1 -> redirect_pc=0x1c008000.
- In DRAIN with 2 left, ws_tlb_flush=1 with inst_resp=1 and refetch_pc=0x1c000044 -> discard_cnt=1, flush_out re-pulses, redirect_pc=0x1c000044 after 1 more resp.
- 4 hs with no resp -> fetch_stall=1 in IDLE; 1 resp -> fetch_stall=0; hs and resp in the same cycle -> outstanding unchanged.
- resetn low while in DRAIN with discard_cnt=2 -> immediately IDLE, all outputs 0, counters 0.
